rv_decode_stage: RTL and testbench

Registered, parametrised RISC-V RV32I instruction decode stage. It replaces the per-format combinational decoders with one block that handles all six base formats (R/I/S/B/U/J) and builds the XLEN-wide sign-extended immediate. It flags illegal encodings and keeps a saturating illegal-instruction count. It sits between fetch and register read, with valid/ready handshakes on both sides, a skid buffer for full throughput, and a flush input for branch redirect.

---
 rtl/rv_decode_stage.sv | 171 +++++++++++++++++
 tb/tb_rv_decode_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_decode_stage.sv
// RV32I decode stage: one decoder for all six base formats, registered output,
// one-entry skid buffer for full throughput, flush for redirects, illegal counter.
module rv_decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_fmt,
  output logic [6:0]       out_opcode,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  input  logic             flush,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [2:0]      fmt;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } dec_t;

  logic [2:0]       w_fmt;
  logic [31:0]      w_imm32;
  dec_t             w_dec;
  logic             w_accept;

  dec_t             r_out;
  logic             r_out_valid;
  dec_t             r_skid;
  logic             r_skid_full;
  logic [CNT_W-1:0] r_cnt;

  always_comb begin
    w_fmt = FMT_ILL;
    case (in_instr[6:0])
      7'b0110011:                                                  w_fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111:  w_fmt = FMT_I;
      7'b0100011:                                                  w_fmt = FMT_S;
      7'b1100011:                                                  w_fmt = FMT_B;
      7'b0110111, 7'b0010111:                                      w_fmt = FMT_U;
      7'b1101111:                                                  w_fmt = FMT_J;
      default:                                                     w_fmt = FMT_ILL;
    endcase
  end

  // Immediates are assembled at 32 bits, then sign-extended once to XLEN.
  always_comb begin
    w_dec        = '0;
    w_imm32      = '0;
    w_dec.fmt    = w_fmt;
    w_dec.opcode = in_instr[6:0];
    case (w_fmt)
      FMT_R: begin
        w_dec.rd     = in_instr[11:7];
        w_dec.rs1    = in_instr[19:15];
        w_dec.rs2    = in_instr[24:20];
        w_dec.funct3 = in_instr[14:12];
        w_dec.funct7 = in_instr[31:25];
      end
      FMT_I: begin
        w_dec.rd     = in_instr[11:7];
        w_dec.rs1    = in_instr[19:15];
        w_dec.funct3 = in_instr[14:12];
        w_imm32      = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      FMT_S: begin
        w_dec.rs1    = in_instr[19:15];
        w_dec.rs2    = in_instr[24:20];
        w_dec.funct3 = in_instr[14:12];
        w_imm32      = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      FMT_B: begin
        w_dec.rs1    = in_instr[19:15];
        w_dec.rs2    = in_instr[24:20];
        w_dec.funct3 = in_instr[14:12];
        w_imm32      = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                        in_instr[11:8], 1'b0};
      end
      FMT_U: begin
        w_dec.rd     = in_instr[11:7];
        w_imm32      = {in_instr[31:12], 12'b0};
      end
      FMT_J: begin
        w_dec.rd     = in_instr[11:7];
        w_imm32      = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                        in_instr[30:21], 1'b0};
      end
      default: begin
        w_dec.illegal = 1'b1;
      end
    endcase
    w_dec.imm = XLEN'($signed(w_imm32));
  end

  // in_ready is the registered complement of skid occupancy, so acceptance
  // can only happen when the skid entry is free to catch the word.
  assign w_accept = in_valid & ~r_skid_full & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_skid      <= '0;
      r_skid_full <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_skid_full <= 1'b0;
    end else if (!r_out_valid || out_ready) begin
      if (r_skid_full) begin
        r_out       <= r_skid;
        r_out_valid <= 1'b1;
        r_skid_full <= 1'b0;
      end else if (w_accept) begin
        r_out       <= w_dec;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid      <= w_dec;
      r_skid_full <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept && w_dec.illegal && !(&r_cnt)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready    = ~r_skid_full;
  assign out_valid   = r_out_valid;
  assign out_fmt     = r_out.fmt;
  assign out_opcode  = r_out.opcode;
  assign out_rd      = r_out.rd;
  assign out_rs1     = r_out.rs1;
  assign out_rs2     = r_out.rs2;
  assign out_funct3  = r_out.funct3;
  assign out_funct7  = r_out.funct7;
  assign out_imm     = r_out.imm;
  assign out_illegal = r_out.illegal;
  assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Scoreboard bench for rv_decode_stage (XLEN=64, CNT_W=2): the driver queues
// hand-computed expectations on acceptance; a monitor pops them on each output transfer.
module tb_rv_decode_stage;
  localparam int XLEN  = 64;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       out_fmt;
  logic [6:0]       out_opcode;
  logic [4:0]       out_rd;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [2:0]       out_funct3;
  logic [6:0]       out_funct7;
  logic [XLEN-1:0]  out_imm;
  logic             out_illegal;
  logic             flush;
  logic [CNT_W-1:0] illegal_cnt;

  rv_decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_fmt(out_fmt), .out_opcode(out_opcode), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3),
    .out_funct7(out_funct7), .out_imm(out_imm), .out_illegal(out_illegal),
    .flush(flush), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_pops   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] fmt, input logic [6:0] opc,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [63:0] imm,
                              input logic ill);
    exp_t e;
    e.fmt = fmt; e.opc = opc; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
    e.f3 = f3; e.f7 = f7; e.imm = imm; e.ill = ill;
    return e;
  endfunction

  // Monitor: every output transfer must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1 && flush === 1'b0) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got opcode %h imm %h, expected no word", out_opcode, out_imm);
      end else begin
        e = sb_q.pop_front();
        chk("out_fmt",     64'(out_fmt),     64'(e.fmt));
        chk("out_opcode",  64'(out_opcode),  64'(e.opc));
        chk("out_rd",      64'(out_rd),      64'(e.rd));
        chk("out_rs1",     64'(out_rs1),     64'(e.rs1));
        chk("out_rs2",     64'(out_rs2),     64'(e.rs2));
        chk("out_funct3",  64'(out_funct3),  64'(e.f3));
        chk("out_funct7",  64'(out_funct7),  64'(e.f7));
        chk("out_imm",     out_imm,          e.imm);
        chk("out_illegal", 64'(out_illegal), 64'(e.ill));
        n_pops++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a word and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic push(input logic [31:0] instr, input exp_t e);
    int budget;
    bit done;
    budget = 0;
    done = 1'b0;
    in_valid = 1'b1;
    in_instr = instr;
    while (!done) begin
      @(negedge clk);
      if (in_ready === 1'b1 && flush === 1'b0) begin
        sb_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      budget++;
      if (!done && budget > 40) begin
        n_checks++;
        n_errors++;
        $display("FAIL push_timeout: instr %h not accepted, in_ready=%b expected 1", instr, in_ready);
        done = 1'b1;
      end
    end
  endtask

  logic [31:0] vin [12];
  exp_t        vexp[12];
  logic [1:0]  cnt_exp [5];
  int          pops_before;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1; flush = 1'b0;

    vin[0]  = 32'h0F56B6B7; vexp[0]  = mk(3'd4, 7'h37, 5'd13, 5'd0, 5'd0, 3'd0, 7'h00, 64'h0000_0000_0F56_B000, 1'b0);
    vin[1]  = 32'h8B549AB7; vexp[1]  = mk(3'd4, 7'h37, 5'd21, 5'd0, 5'd0, 3'd0, 7'h00, 64'hFFFF_FFFF_8B54_9000, 1'b0);
    vin[2]  = 32'hFFF00093; vexp[2]  = mk(3'd1, 7'h13, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    vin[3]  = 32'hFE000EE3; vexp[3]  = mk(3'd3, 7'h63, 5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    vin[4]  = 32'h402081B3; vexp[4]  = mk(3'd0, 7'h33, 5'd3,  5'd1, 5'd2, 3'd0, 7'h20, 64'h0, 1'b0);
    vin[5]  = 32'hFE20AC23; vexp[5]  = mk(3'd2, 7'h23, 5'd0,  5'd1, 5'd2, 3'd2, 7'h00, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    vin[6]  = 32'h008000EF; vexp[6]  = mk(3'd5, 7'h6F, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 64'h8, 1'b0);
    vin[7]  = 32'hFFDFF0EF; vexp[7]  = mk(3'd5, 7'h6F, 5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    vin[8]  = 32'h00001517; vexp[8]  = mk(3'd4, 7'h17, 5'd10, 5'd0, 5'd0, 3'd0, 7'h00, 64'h1000, 1'b0);
    vin[9]  = 32'h00432283; vexp[9]  = mk(3'd1, 7'h03, 5'd5,  5'd6, 5'd0, 3'd2, 7'h00, 64'h4, 1'b0);
    vin[10] = 32'h00008067; vexp[10] = mk(3'd1, 7'h67, 5'd0,  5'd1, 5'd0, 3'd0, 7'h00, 64'h0, 1'b0);
    vin[11] = 32'h00208863; vexp[11] = mk(3'd3, 7'h63, 5'd0,  5'd1, 5'd2, 3'd0, 7'h00, 64'h10, 1'b0);
    cnt_exp[0] = 2'd1; cnt_exp[1] = 2'd2; cnt_exp[2] = 2'd3; cnt_exp[3] = 2'd3; cnt_exp[4] = 2'd3;

    // Reset state, before any clock edge.
    #1;
    chk("rst_out_valid", 64'(out_valid),   64'd0);
    chk("rst_in_ready",  64'(in_ready),    64'd1);
    chk("rst_cnt",       64'(illegal_cnt), 64'd0);
    chk("rst_imm",       out_imm,          64'd0);
    chk("rst_fmt",       64'(out_fmt),     64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1);

    // Legal vectors, streaming at full rate.
    for (int i = 0; i < 12; i++) begin
      push(vin[i], vexp[i]);
      if (i == 0) chk("latency_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    step(2);
    chk("stream_idle_valid", 64'(out_valid),   64'd0);
    chk("legal_cnt",         64'(illegal_cnt), 64'd0);

    // Backpressure: A in output, B in skid, C held at the input.
    out_ready = 1'b0;
    push(vin[9], vexp[9]);
    push(vin[11], vexp[11]);
    chk("bp_in_ready_low", 64'(in_ready),  64'd0);
    chk("bp_out_valid",    64'(out_valid), 64'd1);
    in_valid = 1'b1;
    in_instr = vin[6];
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("bp_hold_ready", 64'(in_ready),   64'd0);
      chk("bp_hold_imm",   out_imm,         64'h4);
      chk("bp_hold_opc",   64'(out_opcode), 64'h03);
    end
    pops_before = n_pops;
    out_ready = 1'b1;
    push(vin[6], vexp[6]);
    in_valid = 1'b0;
    chk("bp_c_valid", 64'(out_valid), 64'd1);
    step(1);
    chk("bp_no_gaps",   64'(n_pops - pops_before), 64'd3);
    chk("bp_end_valid", 64'(out_valid),            64'd0);

    // Flush with output and skid full and a word presented.
    out_ready = 1'b0;
    push(vin[8], vexp[8]);
    push(vin[4], vexp[4]);
    in_valid = 1'b1;
    in_instr = 32'h0000_0000;
    flush = 1'b1;
    @(posedge clk);
    sb_q.delete();
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid),   64'd0);
    chk("flush_in_ready",  64'(in_ready),    64'd1);
    chk("flush_cnt",       64'(illegal_cnt), 64'd0);
    out_ready = 1'b1;
    step(3);
    chk("flush_no_replay", 64'(out_valid), 64'd0);

    // Flush with room at the input and out_ready high: presented word dropped.
    out_ready = 1'b0;
    push(vin[8], vexp[8]);
    in_valid = 1'b1;
    in_instr = 32'h0000_0000;
    out_ready = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    sb_q.delete();
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush2_out_valid", 64'(out_valid),   64'd0);
    chk("flush2_cnt",       64'(illegal_cnt), 64'd0);
    step(2);
    chk("flush2_no_word",   64'(out_valid),   64'd0);

    // Illegal counting with saturation at 3.
    for (int i = 0; i < 5; i++) begin
      push(32'h0000_0000, mk(3'd7, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 64'h0, 1'b1));
      chk("illegal_cnt", 64'(illegal_cnt), 64'(cnt_exp[i]));
    end
    push(32'hFFFF_FFFF, mk(3'd7, 7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 64'h0, 1'b1));
    chk("illegal_cnt_sat", 64'(illegal_cnt), 64'd3);
    in_valid = 1'b0;
    step(2);

    // Reset between edges while a word is held.
    out_ready = 1'b0;
    push(vin[0], vexp[0]);
    in_valid = 1'b0;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid),   64'd0);
    chk("midrst_cnt",       64'(illegal_cnt), 64'd0);
    chk("midrst_in_ready",  64'(in_ready),    64'd1);
    chk("midrst_imm",       out_imm,          64'd0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    step(1);
    push(vin[2], vexp[2]);
    chk("post_rst_latency", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    step(2);
    chk("post_rst_cnt", 64'(illegal_cnt), 64'd0);
    chk("sb_drained",   64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
